// File: rtl/monitor_pkg.sv
// Shared defaults and helpers for the monitor stage: parameter defaults and
// the report-id width function used by the top and its arbiter.
package monitor_pkg;

    localparam int SYM_W_DEF      = 8;
    localparam int NUM_RPT_DEF    = 36;
    localparam int PIPE_DEPTH_DEF = 1;
    localparam int CNT_W_DEF      = 16;

    // A single channel still needs a one-bit id so the port never collapses.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/monitor_rr_arbiter.sv
// Round-robin selector: lowest requesting index at or above ptr, otherwise
// the lowest requesting index overall.
module monitor_rr_arbiter
    import monitor_pkg::*;
#(
    parameter  int N    = NUM_RPT_DEF,
    localparam int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic            hi_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // NOTE: every variable gets a default before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Scanning downwards lets the lowest matching index overwrite the rest.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = ID_W'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        any   = |req;
        idx   = hi_found ? hi_idx : lo_idx;
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/monitor_stage_pipe.sv
// Monitor stage: forwards the symbol/restart stream through PIPE_DEPTH stages
// and drains timestamped automaton reports through a valid/ready port.
module monitor_stage_pipe
    import monitor_pkg::*;
#(
    parameter  int SYM_W      = SYM_W_DEF,
    parameter  int NUM_RPT    = NUM_RPT_DEF,
    parameter  int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter  int CNT_W      = CNT_W_DEF,
    localparam int ID_W       = id_w(NUM_RPT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               restart,
    input  logic [SYM_W-1:0]   top_symbols,
    input  logic [NUM_RPT-1:0] rpt_in,
    output logic [SYM_W-1:0]   out_symbols,
    output logic               out_restart,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [CNT_W-1:0]   rpt_cycle,
    output logic               rpt_overflow,
    input  logic               clear_ovf
);

    logic [SYM_W-1:0]   sym_q [PIPE_DEPTH];
    logic               rst_q [PIPE_DEPTH];
    logic [CNT_W-1:0]   cnt;
    logic [NUM_RPT-1:0] pending;
    logic [CNT_W-1:0]   ts [NUM_RPT];
    logic [ID_W-1:0]    ptr;

    logic [ID_W-1:0]    ptr_eff;
    logic [ID_W-1:0]    id_next;
    logic [ID_W-1:0]    sel_idx;
    logic [NUM_RPT-1:0] sel_grant;
    logic               sel_any;
    logic               handshake;
    logic               load;
    logic               flush;
    logic [NUM_RPT-1:0] new_rpt;
    logic [NUM_RPT-1:0] drain_mask;
    logic [NUM_RPT-1:0] keep_mask;
    logic               ovf_set;

    // NOTE: stages shift with non-blocking assignments so every stage takes
    // its neighbour's value from before the edge, independent of loop order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                sym_q[s] <= '0;
                rst_q[s] <= 1'b0;
            end
        end else if (run) begin
            sym_q[0] <= top_symbols;
            rst_q[0] <= restart;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                sym_q[s] <= sym_q[s-1];
                rst_q[s] <= rst_q[s-1];
            end
        end
    end

    assign out_symbols = sym_q[PIPE_DEPTH-1];
    assign out_restart = rst_q[PIPE_DEPTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= '0;
        else if (run)     cnt <= restart ? '0 : cnt + 1'b1;
    end

    assign handshake = rpt_valid & rpt_ready;
    assign flush     = run & restart;
    assign new_rpt   = (run & ~restart) ? rpt_in : '0;
    assign id_next   = (rpt_id == ID_W'(NUM_RPT - 1)) ? '0 : rpt_id + 1'b1;
    // On an accept the freshly advanced pointer already steers this edge's pick.
    assign ptr_eff   = handshake ? id_next : ptr;

    monitor_rr_arbiter #(.N(NUM_RPT)) u_arb (
        .req   (pending),
        .ptr   (ptr_eff),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // A restart flushes pending work, so nothing is pulled from it that cycle.
    assign load       = (~rpt_valid | rpt_ready) & sel_any & ~flush;
    assign drain_mask = load ? sel_grant : '0;
    assign keep_mask  = pending & ~drain_mask;
    assign ovf_set    = |(new_rpt & keep_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      pending <= '0;
        else if (flush)  pending <= '0;
        else             pending <= keep_mask | new_rpt;
    end

    // NOTE: timestamps are not reset; an entry is only read while its pending
    // bit is set, and that bit is always written together with the entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RPT; i++) begin
            if (new_rpt[i] && !keep_mask[i]) ts[i] <= cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_cycle <= '0;
            ptr       <= '0;
        end else begin
            if (load) begin
                rpt_valid <= 1'b1;
                rpt_id    <= sel_idx;
                rpt_cycle <= ts[sel_idx];
            end else if (handshake) begin
                rpt_valid <= 1'b0;
            end
            if (handshake) ptr <= id_next;
        end
    end

    // A new overflow in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          rpt_overflow <= 1'b0;
        else if (ovf_set)    rpt_overflow <= 1'b1;
        else if (clear_ovf)  rpt_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_monitor_stage_pipe.sv
// Scenario bench for monitor_stage_pipe with a report scoreboard: expected
// reports are queued when driven and compared as each one is accepted.
module tb_monitor_stage_pipe;

    localparam int SYM_W      = 8;
    localparam int NUM_RPT    = 36;
    localparam int PIPE_DEPTH = 2;
    localparam int CNT_W      = 16;
    localparam int ID_W       = 6;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cyc;
    } rpt_t;

    logic               clk;
    logic               reset;
    logic               run;
    logic               restart;
    logic [SYM_W-1:0]   top_symbols;
    logic [NUM_RPT-1:0] rpt_in;
    logic [SYM_W-1:0]   out_symbols;
    logic               out_restart;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [ID_W-1:0]    rpt_id;
    logic [CNT_W-1:0]   rpt_cycle;
    logic               rpt_overflow;
    logic               clear_ovf;

    int         n_checks;
    int         n_fail;
    rpt_t       sb[$];
    logic [CNT_W-1:0] exp_cnt;
    logic       hold_prev;
    rpt_t       held;

    monitor_stage_pipe #(
        .SYM_W(SYM_W), .NUM_RPT(NUM_RPT), .PIPE_DEPTH(PIPE_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .restart      (restart),
        .top_symbols  (top_symbols),
        .rpt_in       (rpt_in),
        .out_symbols  (out_symbols),
        .out_restart  (out_restart),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_id       (rpt_id),
        .rpt_cycle    (rpt_cycle),
        .rpt_overflow (rpt_overflow),
        .clear_ovf    (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference symbol-cycle counter.
    always @(posedge clk or negedge reset) begin
        if (!reset)   exp_cnt <= '0;
        else if (run) exp_cnt <= restart ? '0 : exp_cnt + 1'b1;
    end

    function automatic rpt_t mk(input int id, input logic [CNT_W-1:0] cyc);
        rpt_t r;
        r.id  = ID_W'(id);
        r.cyc = cyc;
        return r;
    endfunction

    // One clock: mid-cycle scoreboard/stability checks, then advance past the edge.
    task automatic step();
        rpt_t e;
        @(negedge clk);
        if (reset === 1'b1) begin
            if (hold_prev) begin
                n_checks++;
                if (rpt_valid !== 1'b1 || rpt_id !== held.id || rpt_cycle !== held.cyc) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b id=%0d cycle=%0d, required valid=1 id=%0d cycle=%0d",
                             rpt_valid, rpt_id, rpt_cycle, held.id, held.cyc);
                end
            end
            if (rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_report: got id=%0d cycle=%0d, required none", rpt_id, rpt_cycle);
                end else begin
                    e = sb.pop_front();
                    if (rpt_id !== e.id || rpt_cycle !== e.cyc) begin
                        n_fail++;
                        $display("FAIL report: got id=%0d cycle=%0d, required id=%0d cycle=%0d",
                                 rpt_id, rpt_cycle, e.id, e.cyc);
                    end
                end
            end
            hold_prev = (rpt_valid === 1'b1) && (rpt_ready !== 1'b1);
            held.id   = rpt_id;
            held.cyc  = rpt_cycle;
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, input string name, output int used);
        used = 0;
        while (sb.size() != 0 && used < budget) begin
            step();
            used++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d reports outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        run         = 1'b0;
        restart     = 1'b0;
        top_symbols = '0;
        rpt_in      = '0;
        rpt_ready   = 1'b0;
        clear_ovf   = 1'b0;
        sb.delete();
        hold_prev   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; restart = 1'b0; top_symbols = '0;
        rpt_in = '0; rpt_ready = 1'b0; clear_ovf = 1'b0; hold_prev = 1'b0;
        #12;
        n_checks += 6;
        if (out_symbols !== '0)   begin n_fail++; $display("FAIL reset_out_symbols: got %0h, required 0", out_symbols); end
        if (out_restart !== 1'b0) begin n_fail++; $display("FAIL reset_out_restart: got %b, required 0", out_restart); end
        if (rpt_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rpt_valid: got %b, required 0", rpt_valid); end
        if (rpt_id !== '0)        begin n_fail++; $display("FAIL reset_rpt_id: got %0d, required 0", rpt_id); end
        if (rpt_cycle !== '0)     begin n_fail++; $display("FAIL reset_rpt_cycle: got %0d, required 0", rpt_cycle); end
        if (rpt_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", rpt_overflow); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_pipeline();
        logic [SYM_W-1:0] syms [4];
        syms[0] = 8'h11; syms[1] = 8'h22; syms[2] = 8'h33; syms[3] = 8'h44;
        run = 1'b1;
        for (int c = 0; c < 4; c++) begin
            top_symbols = syms[c];
            step();
            if (c >= 1) begin
                n_checks++;
                if (out_symbols !== syms[c-1]) begin
                    n_fail++;
                    $display("FAIL pipe_order[%0d]: got %0h, required %0h", c, out_symbols, syms[c-1]);
                end
            end
        end
        run = 1'b0;
        top_symbols = 8'h55;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (out_symbols !== 8'h33) begin
                n_fail++;
                $display("FAIL pipe_hold[%0d]: got %0h, required 33", c, out_symbols);
            end
        end
        run = 1'b1;
        top_symbols = 8'h66;
        step();
        n_checks++;
        if (out_symbols !== 8'h44) begin n_fail++; $display("FAIL pipe_resume: got %0h, required 44", out_symbols); end
        top_symbols = 8'h00;
        restart = 1'b1;
        step();
        n_checks++;
        if (out_symbols !== 8'h66) begin n_fail++; $display("FAIL pipe_resume2: got %0h, required 66", out_symbols); end
        restart = 1'b0;
        n_checks++;
        if (out_restart !== 1'b0) begin n_fail++; $display("FAIL restart_early: got %b, required 0", out_restart); end
        step();
        n_checks++;
        if (out_restart !== 1'b1) begin n_fail++; $display("FAIL restart_fwd: got %b, required 1", out_restart); end
        step();
        n_checks++;
        if (out_restart !== 1'b0) begin n_fail++; $display("FAIL restart_fwd_end: got %b, required 0", out_restart); end
    endtask

    task automatic test_single_report();
        int used;
        run = 1'b1;
        rpt_ready = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (7) step();
        rpt_in = '0;
        rpt_in[5] = 1'b1;
        sb.push_back(mk(5, 16'd7));
        step();
        rpt_in = '0;
        wait_drain(8, "single", used);
        repeat (3) step();
        n_checks++;
        if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL single_beat: got valid=%b, required 0", rpt_valid); end
    endtask

    task automatic test_round_robin();
        int used;
        logic [CNT_W-1:0] c;
        do_reset();
        run = 1'b1;
        rpt_ready = 1'b1;
        c = exp_cnt;
        rpt_in = '0;
        rpt_in[3] = 1'b1; rpt_in[10] = 1'b1; rpt_in[30] = 1'b1;
        sb.push_back(mk(3, c));
        sb.push_back(mk(10, c));
        sb.push_back(mk(30, c));
        step();
        rpt_in = '0;
        wait_drain(10, "rr_first", used);
        // One cycle to load the first report, then one accepted report per cycle.
        n_checks++;
        if (used !== 4) begin n_fail++; $display("FAIL rr_throughput: got %0d cycles, required 4", used); end
        c = exp_cnt;
        rpt_in[3] = 1'b1; rpt_in[31] = 1'b1;
        sb.push_back(mk(31, c));
        sb.push_back(mk(3, c));
        step();
        rpt_in = '0;
        wait_drain(10, "rr_wrap", used);
    endtask

    task automatic test_overflow();
        int used;
        run = 1'b1;
        rpt_ready = 1'b0;
        rpt_in = '0;
        rpt_in[2] = 1'b1;
        sb.push_back(mk(2, exp_cnt));
        step();
        rpt_in = '0;
        repeat (2) step();
        rpt_in[2] = 1'b1;
        sb.push_back(mk(2, exp_cnt));
        step();
        rpt_in = '0;
        n_checks++;
        if (rpt_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_in_output_reg: got %b, required 0", rpt_overflow); end
        rpt_in[2] = 1'b1;
        step();
        rpt_in = '0;
        n_checks++;
        if (rpt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", rpt_overflow); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        n_checks++;
        if (rpt_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, required 0", rpt_overflow); end
        rpt_in[2] = 1'b1;
        clear_ovf = 1'b1;
        step();
        rpt_in = '0;
        clear_ovf = 1'b0;
        n_checks++;
        if (rpt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b, required 1", rpt_overflow); end
        rpt_ready = 1'b1;
        wait_drain(10, "ovf", used);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
    endtask

    task automatic test_restart();
        int used;
        do_reset();
        run = 1'b1;
        rpt_ready = 1'b0;
        rpt_in[1] = 1'b1; rpt_in[4] = 1'b1;
        sb.push_back(mk(1, exp_cnt));
        step();
        rpt_in = '0;
        repeat (2) step();
        restart = 1'b1;
        rpt_in[7] = 1'b1;
        step();
        restart = 1'b0;
        rpt_in = '0;
        rpt_in[9] = 1'b1;
        sb.push_back(mk(9, 16'd0));
        step();
        rpt_in = '0;
        repeat (3) step();
        rpt_ready = 1'b1;
        wait_drain(10, "restart", used);
        repeat (4) step();
        n_checks++;
        if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL restart_flush: got valid=%b id=%0d, required 0", rpt_valid, rpt_id); end
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        rpt_ready = 1'b0;
        top_symbols = 8'hA5;
        rpt_in[6] = 1'b1;
        sb.push_back(mk(6, exp_cnt));
        step();
        rpt_in = '0;
        repeat (2) step();
        rpt_in[6] = 1'b1;
        step();
        rpt_in[6] = 1'b1;
        step();
        rpt_in = '0;
        n_checks++;
        if (rpt_valid !== 1'b1 || out_symbols !== 8'hA5 || rpt_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: got valid=%b sym=%0h ovf=%b, required 1 a5 1", rpt_valid, out_symbols, rpt_overflow);
        end
        #2 reset = 1'b0;
        #1;
        n_checks += 6;
        if (out_symbols !== '0)    begin n_fail++; $display("FAIL async_out_symbols: got %0h, required 0", out_symbols); end
        if (out_restart !== 1'b0)  begin n_fail++; $display("FAIL async_out_restart: got %b, required 0", out_restart); end
        if (rpt_valid !== 1'b0)    begin n_fail++; $display("FAIL async_rpt_valid: got %b, required 0", rpt_valid); end
        if (rpt_id !== '0)         begin n_fail++; $display("FAIL async_rpt_id: got %0d, required 0", rpt_id); end
        if (rpt_cycle !== '0)      begin n_fail++; $display("FAIL async_rpt_cycle: got %0d, required 0", rpt_cycle); end
        if (rpt_overflow !== 1'b0) begin n_fail++; $display("FAIL async_overflow: got %b, required 0", rpt_overflow); end
        sb.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pipeline();
        test_single_report();
        test_round_robin();
        test_overflow();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_stage_pipe.md
MONITOR_STAGE_PIPE -- requirements
Module: monitor_stage_pipe

Interface
REQ-001 SHALL have parameter SYM_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter NUM_RPT, default 36, report channels (1..64).
REQ-003 SHALL have parameter PIPE_DEPTH, default 1, symbol forwarding stages (1..4).
REQ-004 SHALL have parameter CNT_W, default 16, symbol-cycle timestamp width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port run, input, 1, symbol-cycle enable.
REQ-008 SHALL have port restart, input, 1, synchronous trace restart (automaton reset).
REQ-009 SHALL have port top_symbols, input, SYM_W, incoming symbol.
REQ-010 SHALL have port rpt_in, input, NUM_RPT, report pulses from automata.
REQ-011 SHALL have port out_symbols, output, SYM_W, forwarded symbol to next stage.
REQ-012 SHALL have port out_restart, output, 1, forwarded restart.
REQ-013 SHALL have ports rpt_valid (output, 1), rpt_ready (input, 1), rpt_id (output, clog2(NUM_RPT)), rpt_cycle (output, CNT_W): report drain.
REQ-014 SHALL have ports rpt_overflow (output, 1, sticky) and clear_ovf (input, 1).

Function
REQ-015 SHALL delay top_symbols and restart by exactly PIPE_DEPTH run=1 cycles; stages hold when run=0.
REQ-016 SHALL increment cycle counter on each run=1 cycle, wrapping 2^CNT_W-1 -> 0; restart&run loads 0.
REQ-017 SHALL set pending[i] and store ts[i]=counter when rpt_in[i]&run, restart=0.
REQ-018 SHALL set rpt_overflow when rpt_in[i]&run hits already-pending i (not being drained); ts[i] keeps first value.
REQ-019 SHALL clear rpt_overflow only on clear_ovf=1 with no new overflow that cycle (set wins).
REQ-020 SHALL select next id round-robin: lowest pending index >= ptr, else wrap to lowest pending.
REQ-021 SHALL register selection into rpt_id/rpt_cycle, assert rpt_valid, clear that pending bit same edge.
REQ-022 SHALL hold rpt_valid, rpt_id, rpt_cycle stable until rpt_valid&rpt_ready.
REQ-023 SHALL on handshake set ptr=(rpt_id+1) mod NUM_RPT and load next selection same edge (one report/cycle throughput).
REQ-024 SHALL treat rpt_in[i] arriving while i is in output register as new pending, no overflow.
REQ-025 SHALL on restart&run clear all pending bits, ignore rpt_in that cycle; in-flight rpt_valid report held until accepted.
REQ-026 SHALL ignore rpt_in when run=0.

Reset
REQ-027 SHALL on reset=0 clear pipeline, out_symbols=0, out_restart=0, counter=0, pending=0, ptr=0, rpt_valid=0, rpt_id=0, rpt_cycle=0, rpt_overflow=0.
REQ-028 SHALL deassert reset asynchronously-asserted, synchronously-released by upstream; no internal synchroniser.

Structure
REQ-029 SHALL take parameter defaults and id-width function from shared package monitor_pkg.
REQ-030 SHALL implement REQ-020 in sub-module monitor_rr_arbiter (NUM_RPT request vector, ptr in, one-hot/index out).
REQ-031 SHALL target 120-400 lines RTL; ts storage NUM_RPT x CNT_W flops.

Verification
REQ-032 PIPE_DEPTH=2, run=1, symbols 0x11,0x22,0x33 -> out_symbols 0x11 two cycles after input, in order; run=0 gap -> output holds.
REQ-033 rpt_in[5] at counter=7, rpt_ready=1 -> rpt_valid next cycle, rpt_id=5, rpt_cycle=7, single beat.
REQ-034 rpt_in[3],[10],[30] same cycle, ptr=0, rpt_ready=1 -> ids 3,10,30 on consecutive cycles; then rpt_in[3],[31] -> 31 before 3.
REQ-035 rpt_in[2] twice with rpt_ready=0 -> rpt_overflow=1; clear_ovf -> 0; clear_ovf with coincident overflow -> stays 1.
REQ-036 pending ids 1,4 with rpt_ready=0, restart&run -> id 1 stays valid until accepted, id 4 never reported, counter=0.
REQ-037 reset=0 mid-drain asynchronously -> all outputs 0 before next clk edge.
